// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read forwarding and a sequencer that reloads each entry with its index.
//
// state | meaning
// IDLE  | normal read/write; CLR starts a restore sweep
// SWEEP | one entry per edge reloaded with its index; writes are blocked
module reg_file_param #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic [ADDR_W-1:0] SEL_A,
  input  logic [ADDR_W-1:0] SEL_B,
  input  logic              CLR,
  output logic [WIDTH-1:0]  OUT_A,
  output logic [WIDTH-1:0]  OUT_B,
  output logic              BUSY
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              busy_q;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic              wr_ok;

  assign wr_ok = WE & ~busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= WIDTH'(i);
    end else begin
      if (wr_ok) regs[WR_ADDR] <= WR_DATA;
      case (state)
        IDLE: begin
          // A write accepted on this edge still lands; the sweep overwrites it later.
          if (CLR) begin
            state  <= SWEEP;
            busy_q <= 1'b1;
            ptr    <= '0;
          end
        end
        SWEEP: begin
          regs[ptr] <= WIDTH'(ptr);
          ptr       <= ptr + ADDR_W'(1);
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ptr    <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          ptr    <= '0;
        end
      endcase
    end
  end

  // Forwarding only applies to writes that will actually be committed.
  always_comb begin
    OUT_A = regs[SEL_A];
    OUT_B = regs[SEL_B];
    if (BYPASS != 0 && wr_ok && WR_ADDR == SEL_A) OUT_A = WR_DATA;
    if (BYPASS != 0 && wr_ok && WR_ADDR == SEL_B) OUT_B = WR_DATA;
  end

  assign BUSY = busy_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: forwarding and non-forwarding instances
// share stimulus; expectations are queued on drive and compared at sample time.
module tb_reg_file_param;

  logic       clk, rst, we, clr;
  logic [1:0] wr_addr, sel_a, sel_b;
  logic [3:0] wr_data;
  logic [3:0] out_a, out_b, out_a_nb, out_b_nb;
  logic       busy, busy_nb;

  int n_chk = 0;
  int n_err = 0;

  localparam int S_A = 0, S_B = 1, S_BUSY = 2, S_A_NB = 3, S_B_NB = 4;

  typedef struct {
    string      tag;
    int         sig;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  reg_file_param #(.WIDTH(4), .DEPTH(4), .ADDR_W(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .WE(we), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .SEL_A(sel_a), .SEL_B(sel_b), .CLR(clr),
    .OUT_A(out_a), .OUT_B(out_b), .BUSY(busy)
  );

  reg_file_param #(.WIDTH(4), .DEPTH(4), .ADDR_W(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .WE(we), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .SEL_A(sel_a), .SEL_B(sel_b), .CLR(clr),
    .OUT_A(out_a_nb), .OUT_B(out_b_nb), .BUSY(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_exp(input string tag, input int sig, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [3:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        S_A:     obs = out_a;
        S_B:     obs = out_b;
        S_BUSY:  obs = {3'b000, busy};
        S_A_NB:  obs = out_a_nb;
        default: obs = out_b_nb;
      endcase
      chk_val(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; we = 1'b0; clr = 1'b0;
    wr_addr = '0; wr_data = '0; sel_a = '0; sel_b = '0;

    // asynchronous reset between edges, reads follow selects immediately
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      sel_b = 2'(3 - i);
      #1;
      push_exp("rst_a", S_A, 4'(i));
      push_exp("rst_b", S_B, 4'(3 - i));
      push_exp("rst_a_nb", S_A_NB, 4'(i));
      if (i == 0) push_exp("rst_busy", S_BUSY, 4'd0);
      drain();
    end
    tick();
    rst = 1'b0;

    // same-cycle forwarding vs. one-cycle delay
    we = 1'b1; wr_addr = 2'd2; wr_data = 4'hA; sel_a = 2'd2; sel_b = 2'd0;
    #1;
    push_exp("byp_a", S_A, 4'hA);
    push_exp("nobyp_a_pre", S_A_NB, 4'h2);
    push_exp("byp_b_unsel", S_B, 4'h0);
    drain();
    tick();
    we = 1'b0;
    #1;
    push_exp("byp_a_hold", S_A, 4'hA);
    push_exp("nobyp_a_post", S_A_NB, 4'hA);
    drain();

    // dual read, including forwarding on port B
    we = 1'b1; wr_addr = 2'd1; wr_data = 4'h5;
    tick();
    wr_addr = 2'd3; wr_data = 4'hC; sel_b = 2'd3;
    #1;
    push_exp("byp_b", S_B, 4'hC);
    push_exp("nobyp_b_pre", S_B_NB, 4'h3);
    drain();
    tick();
    we = 1'b0; sel_a = 2'd3; sel_b = 2'd3;
    #1;
    push_exp("dual_a", S_A, 4'hC);
    push_exp("dual_b", S_B, 4'hC);
    drain();
    sel_a = 2'd1;
    #1;
    push_exp("dual_a_reg1", S_A, 4'h5);
    drain();

    // restore sweep
    we = 1'b1; wr_data = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 2'(i);
      tick();
    end
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; we = 1'b1; wr_addr = 2'd0; wr_data = 4'h9; sel_a = 2'd0;
    #1;
    push_exp("rs_busy_start", S_BUSY, 4'd1);
    push_exp("rs_no_byp", S_A, 4'hF);
    drain();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) clr = 1'b1;
      if (k == 1) clr = 1'b0;
      if (k == 3) we = 1'b0;
      sel_a = 2'(k);
      sel_b = 2'((k + 1) % 4);
      #1;
      push_exp("rs_restored", S_A, 4'(k));
      push_exp("rs_busy", S_BUSY, (k < 3) ? 4'd1 : 4'd0);
      if (k < 3) push_exp("rs_pending", S_B, 4'hF);
      drain();
    end
    tick();
    sel_a = 2'd0;
    #1;
    push_exp("rs_no_requeue", S_BUSY, 4'd0);
    push_exp("rs_wr_ignored", S_A, 4'h0);
    drain();

    // write colliding with CLR: write lands, sweep overwrites on its 4th edge
    we = 1'b1; wr_addr = 2'd3; wr_data = 4'h7; clr = 1'b1; sel_a = 2'd3;
    tick();
    we = 1'b0; clr = 1'b0;
    #1;
    push_exp("col_busy", S_BUSY, 4'd1);
    push_exp("col_val", S_A, 4'h7);
    drain();
    for (int k = 1; k <= 4; k++) begin
      tick();
      push_exp("col_val", S_A, (k < 4) ? 4'h7 : 4'h3);
      push_exp("col_busy", S_BUSY, (k < 4) ? 4'd1 : 4'd0);
      drain();
    end

    // reset in the middle of a sweep
    we = 1'b1; wr_addr = 2'd2; wr_data = 4'hD;
    tick();
    wr_addr = 2'd3; wr_data = 4'hE;
    tick();
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    push_exp("mid_busy", S_BUSY, 4'd0);
    drain();
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      #1;
      push_exp("mid_reg", S_A, 4'(i));
      drain();
    end
    tick();
    rst = 1'b0;
    we = 1'b1; wr_addr = 2'd0; wr_data = 4'h6; sel_a = 2'd0;
    #1;
    push_exp("mid_wr_pre", S_A_NB, 4'h0);
    drain();
    tick();
    we = 1'b0;
    #1;
    push_exp("mid_wr_post", S_A_NB, 4'h6);
    push_exp("mid_idle", S_BUSY, 4'd0);
    drain();
    tick();
    push_exp("mid_no_resume", S_BUSY, 4'd0);
    push_exp("mid_reg3", S_B, 4'h3);
    sel_b = 2'd3;
    #1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
